maxpool2d: RTL and testbench
============================

// Module: maxpool2d
// PURPOSE
//  Reads the conv2d output feature map from its 1-cycle-latency BRAM (the buffer conv2d writes) and
//  reduces each non-overlapping POOLxPOOL window to its signed maximum. Writes the pooled map to a
//  downstream BRAM. Sits between the conv2d output buffer and the dense/flatten stage.
// PARAMETERS
//  DATA_WIDTH  16  sample width, signed two's complement
//  CHANNELS    1   feature-map channels (processed channel-outer)
//  IN_SIZE     28  input height = width
//  POOL        2   window side and stride; OUT_SIZE = floor(IN_SIZE/POOL)
// PORTS
//  clk       in   1          clock
//  reset     in   1          synchronous, active-high reset
//  start     in   1          begin pooling pass; sampled only in IDLE
//  in_addr   out  IN_AW      read address, (ch*IN_SIZE+r)*IN_SIZE+c; IN_AW=max(1,clog2(CHANNELS*IN_SIZE^2))
//  in_en     out  1          read enable; in_q valid the cycle after in_en
//  in_q      in   DATA_WIDTH read data (registered BRAM output; holds when in_en=0)
//  out_addr  out  OUT_AW     write address, (ch*OUT_SIZE+orow)*OUT_SIZE+ocol; OUT_AW=max(1,clog2(CHANNELS*OUT_SIZE^2))
//  out_en    out  1          write port enable
//  out_we    out  1          write strobe (asserted together with out_en)
//  out_d     out  DATA_WIDTH pooled value
//  done      out  1          pass complete; level, held until next accepted start or reset
// BEHAVIOUR
//  - Reset: state=IDLE; in_en, out_en, out_we, done = 0; in_addr, out_addr, out_d = 0; counters = 0.
//  - FSM: IDLE -(start)-> READ -> DRAIN -> WRITE -> READ (next window) | DONE -> IDLE.
//  - IDLE: start=1 clears done and counters; enters READ next cycle. start is ignored outside IDLE.
//  - READ: POOL^2 consecutive cycles, in_en=1. Window scanned row-major (kr outer, kc inner).
//  - Data capture: a registered valid flag trails in_en by one cycle.
//    First datum of a window loads the running max directly (no compare against 0 or MIN).
//    Each later datum replaces it if signed-greater; ties keep the held value.
//  - DRAIN: 1 cycle, in_en=0; last datum compared.
//  - WRITE: 1 cycle, out_en=out_we=1, out_d=max, out_addr=current output index. Then advance ocol,
//    orow, ch (ch outermost). After the last window, go to DONE.
//  - DONE: done=1 and state returns to IDLE. done stays high until the next start is accepted.
//  - out_en/out_we high only in WRITE; exactly CHANNELS*OUT_SIZE^2 writes per pass, each address once.
//  - Cycles from start accepted to done high = CHANNELS*OUT_SIZE^2*(POOL^2+2)+1.
//  - Odd IN_SIZE: trailing row/column (index >= OUT_SIZE*POOL) is never addressed.
//  - Reset mid-pass: next cycle all outputs at reset values; no further reads or writes.
//  - No arithmetic growth: compare only, out_d width = DATA_WIDTH, full signed range incl. -2^(DW-1).
// CONFIGURATION
//  MAXPOOL_RELU_EN defined: fused ReLU. out_d = (max < 0) ? 0 : max. Timing is unchanged.
//  MAXPOOL_RELU_EN undefined: out_d = raw signed max; negative values pass through.
// TESTING  (BRAM models: 1-cycle registered read, write on out_en&&out_we)
//  1. CHANNELS=1, IN=4, POOL=2, in[i]=i (0..15), pulse start
//     -> out=[5,7,13,15] at addr 0..3; exactly 4 writes; done high 25 cycles after start accepted.
//  2. Same config, in[i]=-(i+1)
//     -> out=[-1,-3,-9,-11] without MAXPOOL_RELU_EN; out=[0,0,0,0] with it.
//  3. Max in last-read slot: in[5]=32767, in[0]=-32768, rest -5 -> out[0]=32767.
//     All-MIN window -> out=-32768 (no RELU).
//  4. Re-pulse start at cycles 3 and 10 of a pass
//     -> ignored: still 4 writes, same results and done timing; done stays high until the next start.
//  5. Assert reset after 2nd write, hold 1 cycle
//     -> next cycle in_en=out_en=done=0, no writes. Restart: full correct result as in test 1.
//  6. IN=5, POOL=2, in[i]=i -> out=[6,8,16,18]; in_addr never in {4,9,14,19,20..24}.
//     CHANNELS=2, IN=4, ch1=ch0+100 -> out[4..7]=[105,107,113,115].

Source files
------------

// File: rtl/maxpool2d_if.sv
// Bus bundle for maxpool2d: start/done control, BRAM read port and BRAM write port.
// Address widths follow from the feature-map geometry parameters.
interface maxpool2d_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned IN_SIZE    = 28,
  parameter int unsigned POOL       = 2
);
  localparam int unsigned OUT_SIZE = IN_SIZE / POOL;
  localparam int unsigned IN_N     = CHANNELS * IN_SIZE * IN_SIZE;
  localparam int unsigned OUT_N    = CHANNELS * OUT_SIZE * OUT_SIZE;
  localparam int unsigned IN_AW    = ($clog2(IN_N) > 0) ? $clog2(IN_N) : 1;
  localparam int unsigned OUT_AW   = ($clog2(OUT_N) > 0) ? $clog2(OUT_N) : 1;

  logic                  start;
  logic [IN_AW-1:0]      in_addr;
  logic                  in_en;
  logic [DATA_WIDTH-1:0] in_q;
  logic [OUT_AW-1:0]     out_addr;
  logic                  out_en;
  logic                  out_we;
  logic [DATA_WIDTH-1:0] out_d;
  logic                  done;

  modport master (
    input  start, in_q,
    output in_addr, in_en, out_addr, out_en, out_we, out_d, done
  );

  modport slave (
    output start, in_q,
    input  in_addr, in_en, out_addr, out_en, out_we, out_d, done
  );
endinterface

// File: rtl/maxpool2d.sv
// Non-overlapping POOLxPOOL signed max pooling from a 1-cycle-latency BRAM into an output BRAM.
// Optional fused ReLU on the pooled value when MAXPOOL_RELU_EN is defined.
module maxpool2d #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned IN_SIZE    = 28,
  parameter int unsigned POOL       = 2
) (
  input logic         clk,
  input logic         reset,
  maxpool2d_if.master bus
);
  localparam int unsigned OUT_SIZE = IN_SIZE / POOL;
  localparam int unsigned IN_N     = CHANNELS * IN_SIZE * IN_SIZE;
  localparam int unsigned OUT_N    = CHANNELS * OUT_SIZE * OUT_SIZE;
  localparam int unsigned IN_AW    = ($clog2(IN_N) > 0) ? $clog2(IN_N) : 1;
  localparam int unsigned OUT_AW   = ($clog2(OUT_N) > 0) ? $clog2(OUT_N) : 1;
  localparam int unsigned KW       = ($clog2(POOL) > 0) ? $clog2(POOL) : 1;
  localparam int unsigned OW       = ($clog2(OUT_SIZE) > 0) ? $clog2(OUT_SIZE) : 1;
  localparam int unsigned CW       = ($clog2(CHANNELS) > 0) ? $clog2(CHANNELS) : 1;

  localparam logic [KW-1:0] K_LAST  = KW'(POOL - 1);
  localparam logic [OW-1:0] O_LAST  = OW'(OUT_SIZE - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StDone} state_e;

  state_e                  state_q, state_d;
  logic [KW-1:0]           kr_q, kr_d, kc_q, kc_d;
  logic [OW-1:0]           orow_q, orow_d, ocol_q, ocol_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic [OUT_AW-1:0]       out_idx_q, out_idx_d;
  logic                    done_q, done_d;
  logic                    vld_q, first_q;
  logic signed [DATA_WIDTH-1:0] max_q;
  logic                    rd_en;
  logic                    last_win;
  int unsigned             rd_row, rd_col, rd_addr;

  assign rd_en    = (state_q == StRead);
  assign last_win = (ch_q == CH_LAST) && (orow_q == O_LAST) && (ocol_q == O_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      kr_q      <= '0;
      kc_q      <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      ch_q      <= '0;
      out_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kr_q      <= kr_d;
      kc_q      <= kc_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      ch_q      <= ch_d;
      out_idx_q <= out_idx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    ch_d      = ch_q;
    out_idx_d = out_idx_q;
    done_d    = done_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StRead;
          kr_d      = '0;
          kc_d      = '0;
          orow_d    = '0;
          ocol_d    = '0;
          ch_d      = '0;
          out_idx_d = '0;
          done_d    = 1'b0;
        end
      end
      StRead: begin
        // Row-major window scan: kc inner, kr outer.
        if (kc_q == K_LAST) begin
          kc_d = '0;
          if (kr_q == K_LAST) begin
            kr_d    = '0;
            state_d = StDrain;
          end else begin
            kr_d = kr_q + 1'b1;
          end
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end
      StDrain: state_d = StWrite;
      StWrite: begin
        out_idx_d = out_idx_q + 1'b1;
        if (last_win) begin
          orow_d    = '0;
          ocol_d    = '0;
          ch_d      = '0;
          out_idx_d = '0;
          state_d   = StDone;
        end else begin
          state_d = StRead;
          if (ocol_q == O_LAST) begin
            ocol_d = '0;
            if (orow_q == O_LAST) begin
              orow_d = '0;
              ch_d   = ch_q + 1'b1;
            end else begin
              orow_d = orow_q + 1'b1;
            end
          end else begin
            ocol_d = ocol_q + 1'b1;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Read data trails in_en by one cycle; the first datum of a window seeds the max.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      max_q   <= '0;
    end else begin
      vld_q   <= rd_en;
      first_q <= rd_en && (kr_q == '0) && (kc_q == '0);
      if (vld_q && (first_q || ($signed(bus.in_q) > max_q))) begin
        max_q <= bus.in_q;
      end
    end
  end

  always_comb begin
    rd_row  = 32'(orow_q) * POOL + 32'(kr_q);
    rd_col  = 32'(ocol_q) * POOL + 32'(kc_q);
    rd_addr = (32'(ch_q) * IN_SIZE + rd_row) * IN_SIZE + rd_col;
  end

  assign bus.in_addr  = IN_AW'(rd_addr);
  assign bus.in_en    = rd_en;
  assign bus.out_addr = out_idx_q;
  assign bus.out_en   = (state_q == StWrite);
  assign bus.out_we   = (state_q == StWrite);
  assign bus.done     = done_q;

`ifdef MAXPOOL_RELU_EN
  assign bus.out_d = max_q[DATA_WIDTH-1] ? '0 : max_q;
`else
  assign bus.out_d = max_q;
`endif

endmodule

// File: tb/tb_maxpool2d.sv
// Scoreboard bench for maxpool2d: a 1x4x4 instance and a 2x5x5 instance (POOL=2), each with
// BRAM models; expected writes are queued at stimulus time and popped by per-instance monitors.
module tb_maxpool2d;
  localparam int unsigned P = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  maxpool2d_if #(.DATA_WIDTH(16), .CHANNELS(1), .IN_SIZE(4), .POOL(2)) bus_a ();
  maxpool2d_if #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(5), .POOL(2)) bus_b ();

  maxpool2d #(.DATA_WIDTH(16), .CHANNELS(1), .IN_SIZE(4), .POOL(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  maxpool2d #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(5), .POOL(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int mem_a [16];
  int mem_b [50];

  always @(posedge clk) if (bus_a.in_en) bus_a.in_q <= 16'(mem_a[bus_a.in_addr]);
  always @(posedge clk) if (bus_b.in_en) bus_b.in_q <= 16'(mem_b[bus_b.in_addr]);

  typedef struct {int addr; int data;} exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  int   wr_cnt [2];
  int   rd_cnt [2];
  int   bad_b;
  int   n_chk;
  int   n_pass;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int mem_get(input int which, input int addr);
    return (which == 0) ? mem_a[addr] : mem_b[addr];
  endfunction

  task automatic push_exp(input int which, input int addr, input int data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    if (which == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  // Reference: max over each non-overlapping PxP window, channel-outer, row-major outputs.
  task automatic push_model(input int which, input int chn, input int insz);
    int os, best, v;
    os = insz / P;
    for (int ch = 0; ch < chn; ch++)
      for (int r = 0; r < os; r++)
        for (int c = 0; c < os; c++) begin
          best = mem_get(which, (ch * insz + r * P) * insz + c * P);
          for (int k = 0; k < P * P; k++) begin
            v = mem_get(which, (ch * insz + r * P + k / P) * insz + c * P + k % P);
            if (v > best) best = v;
          end
          push_exp(which, (ch * os + r) * os + c, relu(best));
        end
  endtask

  function automatic int rand_val();
    logic signed [15:0] v;
    case ($urandom_range(0, 5))
      0: v = 16'sh8000;
      1: v = 16'sh7fff;
      2: v = -16'sd1;
      3: v = 16'sd0;
      default: v = 16'($urandom);
    endcase
    return int'(v);
  endfunction

  task automatic write_check(input int which, input int addr, input int data, input logic we);
    exp_t e;
    int   pending;
    pending = (which == 0) ? q_a.size() : q_b.size();
    chk(which == 0 ? "a_out_we" : "b_out_we", we, 1);
    chk(which == 0 ? "a_write_expected" : "b_write_expected", pending != 0, 1);
    if (pending != 0) begin
      e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
      chk(which == 0 ? "a_out_addr" : "b_out_addr", addr, e.addr);
      chk(which == 0 ? "a_out_d" : "b_out_d", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.in_en) rd_cnt[0]++;
    if (bus_a.out_en) begin
      wr_cnt[0]++;
      write_check(0, int'(bus_a.out_addr), int'($signed(bus_a.out_d)), bus_a.out_we);
    end
  end

  always @(negedge clk) begin
    int a, w;
    if (bus_b.in_en) begin
      rd_cnt[1]++;
      a = int'(bus_b.in_addr);
      w = a % 25;
      if (a >= 50 || w / 5 >= 4 || w % 5 >= 4) bad_b++;
    end
    if (bus_b.out_en) begin
      wr_cnt[1]++;
      write_check(1, int'(bus_b.out_addr), int'($signed(bus_b.out_d)), bus_b.out_we);
    end
  end

  task automatic set_start(input int which, input logic v);
    if (which == 0) bus_a.start = v;
    else bus_b.start = v;
  endtask

  function automatic logic get_done(input int which);
    return (which == 0) ? bus_a.done : bus_b.done;
  endfunction

  // One pass: pulse start, count cycles to done, optionally re-pulse start mid-pass.
  task automatic run_pass(input int which, input bit repulse, input int exp_cycles);
    int  n, wr0;
    bit  got;
    string tag;
    tag = (which == 0) ? "a" : "b";
    wr0 = wr_cnt[which];
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    #1;
    set_start(which, 1'b0);
    chk({tag, "_done_cleared"}, get_done(which), 0);
    n   = 0;
    got = 0;
    while (n < 2000 && !got) begin
      @(posedge clk);
      n++;
      #1;
      set_start(which, repulse && (n == 3 || n == 10));
      if (get_done(which)) got = 1;
    end
    set_start(which, 1'b0);
    chk({tag, "_done_latency"}, n, exp_cycles);
    chk({tag, "_write_count"}, wr_cnt[which] - wr0, exp_cycles / (P * P + 2));
    chk({tag, "_queue_drained"}, (which == 0) ? q_a.size() : q_b.size(), 0);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_done_held"}, get_done(which), 1);
  endtask

  task automatic load_ramp_a();
    for (int i = 0; i < 16; i++) mem_a[i] = i;
  endtask

  task automatic push_ramp_a();
    push_exp(0, 0, 5);
    push_exp(0, 1, 7);
    push_exp(0, 2, 13);
    push_exp(0, 3, 15);
  endtask

  initial begin
    int n, rd0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    n_chk  = 0;
    n_pass = 0;
    bad_b  = 0;
    wr_cnt = '{0, 0};
    rd_cnt = '{0, 0};
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_en", bus_a.in_en, 0);
    chk("rst_out_en", bus_a.out_en, 0);
    chk("rst_out_we", bus_a.out_we, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_in_addr", bus_a.in_addr, 0);
    chk("rst_out_addr", bus_a.out_addr, 0);
    chk("rst_out_d", bus_a.out_d, 0);
    reset = 1'b0;

    // Ramp: windows hold their max in the last-read slot.
    load_ramp_a();
    push_ramp_a();
    run_pass(0, 1'b0, 25);

    // All negative: raw max passes through, or clamps to zero with ReLU.
    for (int i = 0; i < 16; i++) mem_a[i] = -(i + 1);
    push_exp(0, 0, relu(-1));
    push_exp(0, 1, relu(-3));
    push_exp(0, 2, relu(-9));
    push_exp(0, 3, relu(-11));
    run_pass(0, 1'b0, 25);

    // Extremes: MAX in last slot beats MIN in first slot; all-MIN window stays MIN.
    for (int i = 0; i < 16; i++) mem_a[i] = -5;
    mem_a[0] = -32768;
    mem_a[5] = 32767;
    mem_a[10] = -32768;
    mem_a[11] = -32768;
    mem_a[14] = -32768;
    mem_a[15] = -32768;
    push_exp(0, 0, 32767);
    push_exp(0, 1, relu(-5));
    push_exp(0, 2, relu(-5));
    push_exp(0, 3, relu(-32768));
    run_pass(0, 1'b0, 25);

    // start re-pulsed mid-pass must be ignored.
    load_ramp_a();
    push_ramp_a();
    run_pass(0, 1'b1, 25);

    // Reset after the second write: everything stops, nothing more is read or written.
    push_ramp_a();
    rd0 = wr_cnt[0];
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    n = 0;
    while (n < 200 && wr_cnt[0] - rd0 < 2) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("a_reset_setup_writes", wr_cnt[0] - rd0, 2);
    q_a.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("a_reset_in_en", bus_a.in_en, 0);
    chk("a_reset_out_en", bus_a.out_en, 0);
    chk("a_reset_done", bus_a.done, 0);
    rd0 = rd_cnt[0];
    n   = wr_cnt[0];
    repeat (30) @(posedge clk);
    chk("a_reset_no_reads", rd_cnt[0] - rd0, 0);
    chk("a_reset_no_writes", wr_cnt[0] - n, 0);
    load_ramp_a();
    push_ramp_a();
    run_pass(0, 1'b0, 25);

    // Randomized passes against the reference model.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) mem_a[i] = rand_val();
      push_model(0, 1, 4);
      run_pass(0, 1'b0, 25);
    end

    // Two channels, odd size: ch1 = ch0 + 100; trailing row/col never read.
    for (int i = 0; i < 25; i++) begin
      mem_b[i]      = i;
      mem_b[25 + i] = i + 100;
    end
    push_exp(1, 0, 6);
    push_exp(1, 1, 8);
    push_exp(1, 2, 16);
    push_exp(1, 3, 18);
    push_exp(1, 4, 106);
    push_exp(1, 5, 108);
    push_exp(1, 6, 116);
    push_exp(1, 7, 118);
    rd0 = rd_cnt[1];
    run_pass(1, 1'b0, 49);
    chk("b_read_count", rd_cnt[1] - rd0, 32);

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 50; i++) mem_b[i] = rand_val();
      push_model(1, 2, 5);
      run_pass(1, 1'b0, 49);
    end
    chk("b_illegal_read_addrs", bad_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
